bp_update_scheduler: RTL and testbench



---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_upd_fifo.sv | 55 +++++
 rtl/bp_update_scheduler.sv | 113 +++++++++++
 tb/tb_bp_update_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update scheduler: BTB geometry,
// the queued update record and the sweep/run state encoding.
package bp_pkg;

  localparam int IDX_W = 3;
  localparam int TAG_W = 31 - IDX_W;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             taken;
  } bp_upd_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } bp_state_e;

  // Instructions are halfword aligned, so pc[0] never selects an entry.
  function automatic bp_upd_t make_upd(input logic [31:0] pc,
                                       input logic [31:0] target,
                                       input logic        taken);
    bp_upd_t u;
    u.idx    = pc[IDX_W:1];
    u.tag    = pc[31:IDX_W+1];
    u.target = target;
    u.taken  = taken;
    return u;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// DEPTH-entry synchronous FIFO of predictor updates. The caller guarantees
// push only when not full (or popping) and pop only when not empty.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  bp_upd_t                  din,
  output bp_upd_t                  dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  bp_upd_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/bp_update_scheduler.sv
// Queues resolved-branch updates and drives the single BTB write port,
// giving the post-reset / flush invalidation sweep absolute priority.
module bp_update_scheduler #(
  parameter int DEPTH = 4,
  parameter int IDX_W = bp_pkg::IDX_W,
  parameter int TAG_W = bp_pkg::TAG_W,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               memory_stall,
  input  logic               flush_req,
  input  logic               resolve_valid,
  input  logic [31:0]        resolve_pc,
  input  logic               resolve_taken,
  input  logic [31:0]        resolve_target,
  output logic               upd_valid,
  output logic [IDX_W-1:0]   upd_idx,
  output logic [TAG_W-1:0]   upd_tag,
  output logic [31:0]        upd_target,
  output logic               upd_taken,
  output logic               inv_valid,
  output logic [IDX_W-1:0]   inv_idx,
  output logic               busy,
  output logic               q_full,
  output logic [CNT_W-1:0]   drop_cnt
);

  // upd_valid / inv_valid are single-cycle strobes with no ready: the
  // predictor write port must accept whatever is presented that cycle.

  localparam int QC_W = $clog2(DEPTH) + 1;

  bp_pkg::bp_state_e   state;
  logic [IDX_W-1:0]    sweep_idx;
  bp_pkg::bp_upd_t     new_upd;
  bp_pkg::bp_upd_t     head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [QC_W-1:0]     fifo_count;
  logic                pop;
  logic                push;
  logic                drop;

  assign new_upd = bp_pkg::make_upd(resolve_pc, resolve_target, resolve_taken);

  // flush_req outranks both queue operations; its resolve simply vanishes.
  assign pop  = (state == bp_pkg::RUN) && !fifo_empty && !memory_stall && !flush_req;
  assign push = resolve_valid && !flush_req && (!fifo_full || pop);
  assign drop = resolve_valid && !flush_req && fifo_full && !pop;

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush_req),
    .push  (push),
    .pop   (pop),
    .din   (new_upd),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= bp_pkg::CLEAR;
      sweep_idx  <= '0;
      upd_valid  <= 1'b0;
      upd_idx    <= '0;
      upd_tag    <= '0;
      upd_target <= '0;
      upd_taken  <= 1'b0;
      inv_valid  <= 1'b0;
      inv_idx    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;

      if (flush_req) begin
        state     <= bp_pkg::CLEAR;
        sweep_idx <= '0;
        inv_valid <= 1'b0;
        upd_valid <= 1'b0;
      end else begin
        case (state)
          bp_pkg::CLEAR: begin
            inv_valid <= 1'b1;
            inv_idx   <= sweep_idx;
            sweep_idx <= sweep_idx + 1'b1;
            upd_valid <= 1'b0;
            if (sweep_idx == '1) state <= bp_pkg::RUN;
          end
          bp_pkg::RUN: begin
            inv_valid <= 1'b0;
            upd_valid <= pop;
            if (pop) begin
              upd_idx    <= head.idx;
              upd_tag    <= head.tag;
              upd_target <= head.target;
              upd_taken  <= head.taken;
            end
          end
          default: state <= bp_pkg::CLEAR;
        endcase
      end
    end
  end

  assign busy   = (state == bp_pkg::CLEAR);
  assign q_full = (fifo_count == QC_W'(DEPTH));

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: sweep timing, table of address-split
// vectors, stall/full/drop behaviour, flush and async reset corners.
module tb_bp_update_scheduler;

  localparam int IDX_W = 3;
  localparam int TAG_W = 28;
  localparam int CNT_W = 8;

  logic              clk;
  logic              rst_n;
  logic              memory_stall;
  logic              flush_req;
  logic              resolve_valid;
  logic [31:0]       resolve_pc;
  logic              resolve_taken;
  logic [31:0]       resolve_target;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic [31:0]       upd_target;
  logic              upd_taken;
  logic              inv_valid;
  logic [IDX_W-1:0]  inv_idx;
  logic              busy;
  logic              q_full;
  logic [CNT_W-1:0]  drop_cnt;

  bp_update_scheduler #(.DEPTH(4), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .memory_stall   (memory_stall),
    .flush_req      (flush_req),
    .resolve_valid  (resolve_valid),
    .resolve_pc     (resolve_pc),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_tag        (upd_tag),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .inv_valid      (inv_valid),
    .inv_idx        (inv_idx),
    .busy           (busy),
    .q_full         (q_full),
    .drop_cnt       (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  int n_cmp;
  int n_err;
  int upd_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_of(input logic [31:0] pc, input logic taken,
                                         input logic [31:0] tgt);
    return {pc[3:1], pc[31:4], tgt, taken};
  endfunction

  always @(negedge clk) begin
    if (rst_n && upd_valid) begin
      upd_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL upd_unexpected: got idx %0d tag %0h target %0h, expected no update",
                 upd_idx, upd_tag, upd_target);
      end else begin
        mon_e = exp_q.pop_front();
        check("upd_fields", {upd_idx, upd_tag, upd_target, upd_taken}, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input bit expect_kept);
    resolve_valid  = 1'b1;
    resolve_pc     = pc;
    resolve_taken  = taken;
    resolve_target = tgt;
    if (expect_kept) exp_q.push_back(exp_of(pc, taken, tgt));
  endtask

  task automatic drive_rand(input bit expect_kept);
    drive($urandom, 1'($urandom_range(0, 1)), $urandom, expect_kept);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int t = 0; t < max_cycles && exp_q.size() != 0; t++) step();
    check("drain", exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0]      pc;
    logic             taken;
    logic [31:0]      target;
    logic [IDX_W-1:0] exp_idx;
    logic [TAG_W-1:0] exp_tag;
  } vec_t;

  vec_t vecs[7];
  int   base;

  initial begin
    vecs[0] = '{32'h0000_1A46, 1'b1, 32'h0000_2000, 3'd3, 28'h00001A4};
    vecs[1] = '{32'hFFFF_FFFE, 1'b0, 32'h1234_5678, 3'd7, 28'hFFFFFFF};
    vecs[2] = '{32'h8000_0002, 1'b1, 32'hCAFE_0000, 3'd1, 28'h8000000};
    vecs[3] = '{32'h1234_5678, 1'b1, 32'h0000_0010, 3'd4, 28'h1234567};
    vecs[4] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 3'd0, 28'h0000000};
    vecs[5] = '{32'hDEAD_BEEC, 1'b0, 32'hFFFF_FFFF, 3'd6, 28'hDEADBEE};
    vecs[6] = '{32'h0000_000F, 1'b1, 32'h8765_4321, 3'd7, 28'h0000000};

    n_cmp = 0; n_err = 0; upd_seen = 0;
    rst_n = 1'b0; memory_stall = 1'b0; flush_req = 1'b0;
    resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0; resolve_target = '0;

    // Reset state and power-up sweep
    repeat (2) step();
    check("rst_busy", busy, 1);
    check("rst_inv_valid", inv_valid, 0);
    check("rst_upd", {upd_valid, upd_idx, upd_tag, upd_target, upd_taken}, 0);
    check("rst_qfull_drop", {q_full, drop_cnt}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("sweep_inv_valid", inv_valid, 1);
      check("sweep_inv_idx", inv_idx, i);
      check("sweep_busy", busy, (i != 7));
    end
    step();
    check("sweep_end_inv", inv_valid, 0);
    check("sweep_end_busy", busy, 0);

    // Table: address split and minimum latency k -> k+2
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({vecs[i].exp_idx, vecs[i].exp_tag, vecs[i].target, vecs[i].taken});
      resolve_valid = 1'b1; resolve_pc = vecs[i].pc;
      resolve_taken = vecs[i].taken; resolve_target = vecs[i].target;
      step();
      resolve_valid = 1'b0;
      check("lat_k1", upd_valid, 0);
      step();
      check("lat_k2", upd_valid, 1);
      check("vec_idx", upd_idx, vecs[i].exp_idx);
      check("vec_tag", upd_tag, vecs[i].exp_tag);
      step();
    end

    // Stall: fill 4, drop a 5th, then drain in order
    memory_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin drive_rand(1); step(); end
    check("stall_qfull", q_full, 1);
    drive_rand(0);
    step();
    resolve_valid = 1'b0;
    check("stall_drop", drop_cnt, 1);
    check("stall_qfull2", q_full, 1);
    base = upd_seen;
    memory_stall = 1'b0;
    repeat (8) step();
    check("stall_drain_cnt", upd_seen - base, 4);
    check("stall_qempty", q_full, 0);

    // Full FIFO streaming: pop+push each cycle, no drops
    memory_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin drive_rand(1); step(); end
    resolve_valid = 1'b0;
    check("stream_prefull", q_full, 1);
    memory_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_rand(1);
      step();
      check("stream_upd", upd_valid, 1);
      check("stream_qfull", q_full, 1);
    end
    resolve_valid = 1'b0;
    check("stream_drop", drop_cnt, 1);
    wait_drain(10);

    // Flush with 3 queued plus a simultaneous resolve
    memory_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin drive_rand(1); step(); end
    drive_rand(0);
    flush_req = 1'b1;
    exp_q.delete();
    step();
    flush_req = 1'b0; resolve_valid = 1'b0;
    check("flush_busy", busy, 1);
    check("flush_qfull", q_full, 0);
    check("flush_drop", drop_cnt, 1);
    check("flush_upd", upd_valid, 0);
    memory_stall = 1'b0;
    base = upd_seen;
    for (int i = 0; i < 8; i++) begin
      step();
      check("flush_inv_valid", inv_valid, 1);
      check("flush_inv_idx", inv_idx, i);
    end
    repeat (4) step();
    check("flush_no_upd", upd_seen - base, 0);

    // Flush mid-sweep at idx 5; resolves during the sweep held until RUN
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int t = 0; t < 12 && !(inv_valid && inv_idx == 3'd5); t++) step();
    check("mid_reach5", {inv_valid, inv_idx}, {1'b1, 3'd5});
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    drive_rand(1);
    step();
    check("mid_restart_idx", {inv_valid, inv_idx}, {1'b1, 3'd0});
    drive_rand(1);
    step();
    resolve_valid = 1'b0;
    base = upd_seen;
    for (int t = 0; t < 10 && busy; t++) begin
      check("mid_no_upd_busy", upd_valid, 0);
      step();
    end
    check("mid_busy_fell", busy, 0);
    wait_drain(6);
    check("mid_upd_cnt", upd_seen - base, 2);
    check("mid_drop", drop_cnt, 1);

    // Drop counter saturation
    memory_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin drive_rand(1); step(); end
    for (int i = 0; i < 300; i++) begin drive_rand(0); step(); end
    resolve_valid = 1'b0;
    check("drop_saturate", drop_cnt, 8'hFF);
    memory_stall = 1'b0;
    wait_drain(8);

    // Asynchronous reset mid-queue
    memory_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin drive_rand(1); step(); end
    resolve_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1);
    check("arst_outs", {inv_valid, upd_valid, q_full, drop_cnt}, 0);
    exp_q.delete();
    memory_stall = 1'b0;
    step();
    rst_n = 1'b1;
    base = upd_seen;
    step();
    check("arst_sweep0", {inv_valid, inv_idx}, {1'b1, 3'd0});
    repeat (14) step();
    check("arst_no_upd", upd_seen - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
